hazard_stall_ctrl: RTL and testbench

- Hazard and stall sequencer for the 5-stage MIPS pipeline.
- Keeps shadow copies of the destination register and Tnew for the E and M stages, and tracks a multiply/divide busy countdown.
- From these it drives the F/D register enable, the PC enable, the D/E bubble insert, and the delay-slot nullify pair (Check/Flag) of the F/D register.
- Sits beside the decoder in D stage; it is the only source of stall decisions.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/md_busy_counter.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 95 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and helpers for the MIPS pipeline control blocks.
// Holds the multiply/divide op codes, the "operand unused" Tuse marker and the hazard helpers.
package mips_pkg;

    localparam logic [1:0] MD_NONE = 2'd0;
    localparam logic [1:0] MD_MULT = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_HILO = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DFLT = 5;
    localparam int DIV_CYCLES_DFLT  = 10;

    // Tnew one stage later, saturating at zero.
    function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

    // A source register hazards against one stage when that stage writes it
    // and the result is not ready before the consumer needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        if (src == 5'd0 || tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return ((src == e_a3) && (tuse < e_tnew)) ||
               ((src == m_a3) && (tuse < m_tnew));
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO busy countdown: reloads when a mult/div sits in E, then counts down to zero.
// md_busy covers both the cycle the op is in E and the remaining countdown.
module md_busy_counter
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] e_md,
    output logic       md_busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (e_md == MD_MULT) begin
            cnt_d = CNT_W'(MULT_CYCLES);
        end else if (e_md == MD_DIV) begin
            cnt_d = CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0) || (e_md == MD_MULT) || (e_md == MD_DIV);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage hazard and stall sequencer: shadows E/M destination and Tnew, decides stalls,
// and drives the PC/F-D enables, the D/E bubble and the branch-likely nullify pair.
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic [1:0] D_md_op,
    input  logic       D_likely,
    input  logic       D_taken,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_flush,
    output logic       fd_check,
    output logic       fd_flag,
    output logic       md_busy
);

    logic [4:0] e_a3_q, e_a3_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [1:0] e_md_q, e_md_d;
    logic [4:0] m_a3_q, m_a3_d;
    logic [1:0] m_tnew_q, m_tnew_d;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_cnt (
        .clk     (clk),
        .reset   (reset),
        .e_md    (e_md_q),
        .md_busy (md_busy)
    );

    always_comb begin
        stall_rs = src_hazard(D_rs, D_Tuse_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
        stall_rt = src_hazard(D_rt, D_Tuse_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
        stall_md = (D_md_op != MD_NONE) && md_busy;
        stall    = stall_rs | stall_rt | stall_md;
    end

    // A stalled D instruction must not advance, so E receives a bubble instead.
    always_comb begin
        m_a3_d   = e_a3_q;
        m_tnew_d = tnew_age(e_tnew_q);
        e_a3_d   = D_A3;
        e_tnew_d = D_Tnew;
        e_md_d   = D_md_op;
        if (stall) begin
            e_a3_d   = 5'd0;
            e_tnew_d = 2'd0;
            e_md_d   = MD_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            e_md_q   <= MD_NONE;
            m_a3_q   <= 5'd0;
            m_tnew_q <= 2'd0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            e_md_q   <= e_md_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
        end
    end

    assign pc_en    = ~stall;
    assign fd_en    = ~stall;
    assign de_flush = stall;
    // Holding F/D takes priority over annulling the delay slot.
    assign fd_check = D_likely & ~stall;
    assign fd_flag  = D_taken;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed pipeline scenarios followed by
// randomized D-stage traffic, all compared against a pipeline-occupancy reference model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew, D_md_op;
    logic       D_likely, D_taken;
    logic       pc_en, fd_en, de_flush, fd_check, fd_flag, md_busy;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: what occupies E and M, and how many cycles HI/LO remains busy.
    int e_dst, e_ready, e_mdop, m_dst, m_ready, busy_left;

    int obs_pc_en, obs_fd_en, obs_de_flush, obs_fd_check, obs_fd_flag, obs_md_busy;

    hazard_stall_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_Tuse_rs (D_Tuse_rs),
        .D_Tuse_rt (D_Tuse_rt),
        .D_A3      (D_A3),
        .D_Tnew    (D_Tnew),
        .D_md_op   (D_md_op),
        .D_likely  (D_likely),
        .D_taken   (D_taken),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .de_flush  (de_flush),
        .fd_check  (fd_check),
        .fd_flag   (fd_flag),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int needs_wait(input int src, input int tuse);
        if (src == 0 || tuse == 3) return 0;
        if (src == e_dst && tuse < e_ready) return 1;
        if (src == m_dst && tuse < m_ready) return 1;
        return 0;
    endfunction

    function automatic int model_busy();
        return (busy_left > 0 || e_mdop == 1 || e_mdop == 2) ? 1 : 0;
    endfunction

    function automatic int model_stall();
        int hold;
        hold = needs_wait(int'(D_rs), int'(D_Tuse_rs)) | needs_wait(int'(D_rt), int'(D_Tuse_rt));
        if (D_md_op != 2'd0 && model_busy() != 0) hold = 1;
        return hold;
    endfunction

    task automatic model_reset();
        e_dst = 0; e_ready = 0; e_mdop = 0; m_dst = 0; m_ready = 0; busy_left = 0;
    endtask

    // Compare outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int st;
        @(negedge clk);
        st = model_stall();
        obs_pc_en = int'(pc_en);     obs_fd_en = int'(fd_en);
        obs_de_flush = int'(de_flush); obs_fd_check = int'(fd_check);
        obs_fd_flag = int'(fd_flag); obs_md_busy = int'(md_busy);
        check("pc_en",    obs_pc_en,    1 - st);
        check("fd_en",    obs_fd_en,    1 - st);
        check("de_flush", obs_de_flush, st);
        check("fd_check", obs_fd_check, (D_likely && st == 0) ? 1 : 0);
        check("fd_flag",  obs_fd_flag,  int'(D_taken));
        check("md_busy",  obs_md_busy,  model_busy());
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_dst   = e_dst;
            m_ready = (e_ready > 0) ? e_ready - 1 : 0;
            if (e_mdop == 1)      busy_left = 5;
            else if (e_mdop == 2) busy_left = 10;
            else if (busy_left > 0) busy_left--;
            if (st != 0) begin
                e_dst = 0; e_ready = 0; e_mdop = 0;
            end else begin
                e_dst = int'(D_A3); e_ready = int'(D_Tnew); e_mdop = int'(D_md_op);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        D_A3 = 5'd0; D_Tnew = 2'd0; D_md_op = 2'd0; D_likely = 1'b0; D_taken = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom_range(1, 31));
        endcase
    endfunction

    // Count stalled cycles until the D instruction proceeds; a blown budget counts as a failure.
    task automatic count_stalls(input string tag, input int expected);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (obs_pc_en != 0) break;
            n++;
        end
        check(tag, n, expected);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        check("rst_pc_en", obs_pc_en, 1);
        check("rst_md_busy", obs_md_busy, 0);
        reset = 1'b0;

        // lw $t0 in E, dependent add in D: one-cycle stall.
        D_A3 = 5'd8; D_Tnew = 2'd2;
        cycle();
        idle_inputs();
        D_rs = 5'd8; D_Tuse_rs = 2'd1;
        cycle();
        check("lw_use_stall", obs_de_flush, 1);
        cycle();
        check("lw_use_release", obs_pc_en, 1);

        // Register 0 never stalls.
        idle_inputs();
        D_A3 = 5'd0; D_Tnew = 2'd2;
        cycle();
        idle_inputs();
        D_rs = 5'd0; D_Tuse_rs = 2'd0;
        cycle();
        check("r0_no_stall", obs_pc_en, 1);

        // mult then mfhi: six stalled cycles.
        idle_inputs();
        D_md_op = 2'd1;
        cycle();
        D_md_op = 2'd3;
        count_stalls("mfhi_after_mult", 6);

        // div interrupted by reset with four cycles left.
        idle_inputs();
        D_md_op = 2'd2;
        cycle();
        idle_inputs();
        for (int i = 0; i < 20 && busy_left != 4; i++) cycle();
        check("div_cnt_at_4", int'(dut.u_md_cnt.cnt_q), 4);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        D_md_op = 2'd3;
        cycle();
        check("post_rst_busy", obs_md_busy, 0);
        check("post_rst_stall", obs_pc_en, 1);

        // Not-taken likely branch annuls its slot unless D is held.
        idle_inputs();
        D_likely = 1'b1; D_taken = 1'b0;
        cycle();
        check("likely_check", obs_fd_check, 1);
        check("likely_flag", obs_fd_flag, 0);
        idle_inputs();
        D_A3 = 5'd9; D_Tnew = 2'd3;
        cycle();
        idle_inputs();
        D_rs = 5'd9; D_Tuse_rs = 2'd0; D_likely = 1'b1;
        cycle();
        check("likely_held_check", obs_fd_check, 0);
        check("likely_held_fd_en", obs_fd_en, 0);

        // Back-to-back mult waits the full countdown, then reloads.
        idle_inputs();
        for (int i = 0; i < 12; i++) cycle();
        D_md_op = 2'd1;
        cycle();
        count_stalls("mult_after_mult", 6);
        idle_inputs();
        cycle();
        check("mult_reload", int'(dut.u_md_cnt.cnt_q), 5);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            D_rs      = pick_reg();
            D_rt      = pick_reg();
            D_A3      = pick_reg();
            D_Tuse_rs = 2'($urandom_range(0, 3));
            D_Tuse_rt = 2'($urandom_range(0, 3));
            D_Tnew    = 2'($urandom_range(0, 3));
            D_md_op   = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            D_likely  = 1'($urandom_range(0, 1));
            D_taken   = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
